// File: rtl/csa_accum_resolve.sv
// Carry-save accumulator for the GEMV reduction tree: 4:2-compresses each incoming
// sum/carry pair into a redundant accumulator, then resolves it with a split two-cycle add.
module csa_accum_resolve #(
  parameter int S_WIDTH   = 18,
  parameter int C_WIDTH   = 17,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [S_WIDTH-1:0]   in_sum,
  input  logic [C_WIDTH-1:0]   in_carry,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_beats
);

  localparam int HALF = ACC_WIDTH / 2;

  typedef enum logic [1:0] {
    ACCUM      = 2'd0,
    RESOLVE_LO = 2'd1,
    RESOLVE_HI = 2'd2,
    OUT        = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ACC_WIDTH-1:0] acc_s, acc_c;
  logic [CNT_WIDTH-1:0] beat_count;
  logic [HALF-1:0]      lo;
  logic                 lo_carry;

  logic                 accept, handshake;
  logic [ACC_WIDTH-1:0] sum_ext, carry_ext;
  logic [ACC_WIDTH-1:0] s1, c1, s2, c2;
  logic [HALF:0]        lo_sum;
  logic [HALF-1:0]      hi_sum;

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  assign sum_ext   = {{(ACC_WIDTH-S_WIDTH){1'b0}}, in_sum};
  assign carry_ext = {{(ACC_WIDTH-C_WIDTH){1'b0}}, in_carry};

  // Two 3:2 layers; carries shift left and drop the top bit, giving mod 2^ACC_WIDTH.
  assign s1 = acc_s ^ acc_c ^ sum_ext;
  assign c1 = ((acc_s & acc_c) | (acc_s & sum_ext) | (acc_c & sum_ext)) << 1;
  assign s2 = s1 ^ c1 ^ carry_ext;
  assign c2 = ((s1 & c1) | (s1 & carry_ext) | (c1 & carry_ext)) << 1;

  assign lo_sum = {1'b0, acc_s[HALF-1:0]} + {1'b0, acc_c[HALF-1:0]};
  assign hi_sum = acc_s[ACC_WIDTH-1:HALF] + acc_c[ACC_WIDTH-1:HALF]
                + {{(HALF-1){1'b0}}, lo_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last) next_state = RESOLVE_LO;
      end
      RESOLVE_LO: next_state = RESOLVE_HI;
      RESOLVE_HI: next_state = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ACCUM;
      end
      default: next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s      <= '0;
      acc_c      <= '0;
      beat_count <= '0;
      lo         <= '0;
      lo_carry   <= 1'b0;
      out_data   <= '0;
      out_beats  <= '0;
    end else begin
      if (accept) begin
        acc_s <= s2;
        acc_c <= c2;
        if (beat_count != {CNT_WIDTH{1'b1}}) beat_count <= beat_count + 1'b1;
      end
      if (state == RESOLVE_LO) begin
        lo       <= lo_sum[HALF-1:0];
        lo_carry <= lo_sum[HALF];
      end
      if (state == RESOLVE_HI) begin
        out_data  <= {hi_sum, lo};
        out_beats <= beat_count;
      end
      // The accumulator is cleared only once the consumer has taken the result.
      if (handshake) begin
        acc_s      <= '0;
        acc_c      <= '0;
        beat_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Randomized and directed bench for csa_accum_resolve; expected results come from a
// plain modular-sum reference model of the dot product.
module tb_csa_accum_resolve;

  localparam int S_WIDTH   = 18;
  localparam int C_WIDTH   = 17;
  localparam int ACC_WIDTH = 24;
  localparam int CNT_WIDTH = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [S_WIDTH-1:0]   in_sum;
  logic [C_WIDTH-1:0]   in_carry;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] out_beats;

  int compared   = 0;
  int mismatched = 0;

  logic [ACC_WIDTH-1:0] model_sum;
  int                   model_beats;

  csa_accum_resolve #(
    .S_WIDTH(S_WIDTH), .C_WIDTH(C_WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int satBeats(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic resetModel();
    model_sum   = '0;
    model_beats = 0;
  endtask

  // Drives one beat and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [S_WIDTH-1:0] s, input logic [C_WIDTH-1:0] c,
                               input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_sum    = S_WIDTH'($urandom);
    in_carry  = C_WIDTH'($urandom);
    model_sum = model_sum + ACC_WIDTH'(s) + ACC_WIDTH'(c);
    model_beats++;
  endtask

  task automatic waitValid();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  // Waits for a result, holds off out_ready for 'delay' cycles while waving junk at the
  // input, then completes the handshake and checks the result against the model.
  task automatic collectResult(input string tag, input int delay);
    waitValid();
    checkOutput({tag, "_data"}, 32'(out_data), 32'(model_sum));
    checkOutput({tag, "_beats"}, 32'(out_beats), 32'(satBeats(model_beats)));
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_data"}, 32'(out_data), 32'(model_sum));
      checkOutput({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    resetModel();
  endtask

  initial begin
    int low_cycles;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    resetModel();
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_beats", 32'(out_beats), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat with latency check: valid appears after the second edge past accept.
    applyStimulus(18'h3FFFF, 17'h1FFFF, 1'b1);
    checkOutput("single_lat0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("single_lat1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("single_lat2", 32'(out_valid), 32'd1);
    checkOutput("single_const", 32'(out_data), 32'h05FFFE);
    collectResult("single", 0);

    applyStimulus(18'hFFF, 17'h001, 1'b1);
    waitValid();
    checkOutput("halfcarry_const", 32'(out_data), 32'h001000);
    collectResult("halfcarry", 0);

    // Multi-beat with out_ready pre-asserted: in_ready low for exactly three cycles.
    for (int b = 0; b < 4; b++) applyStimulus(18'd1000, 17'd24, b == 3);
    out_ready  = 1'b1;
    low_cycles = 0;
    while (!in_ready && low_cycles < 20) begin
      if (out_valid) begin
        checkOutput("multi_const", 32'(out_data), 32'd4096);
        checkOutput("multi_beats", 32'(out_beats), 32'd4);
      end
      low_cycles++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checkOutput("multi_ready_low", 32'(low_cycles), 32'd3);
    resetModel();

    for (int b = 0; b < 65; b++) applyStimulus(18'h3FFFF, 17'h1FFFF, b == 64);
    waitValid();
    checkOutput("wrap_const", 32'(out_data), 32'h85FF7E);
    checkOutput("wrap_beats", 32'(out_beats), 32'd65);
    collectResult("wrap", 0);

    for (int b = 0; b < 260; b++) applyStimulus(18'd1, 17'd0, b == 259);
    waitValid();
    checkOutput("sat_beats", 32'(out_beats), 32'd255);
    checkOutput("sat_data", 32'(out_data), 32'd260);
    collectResult("sat", 0);

    applyStimulus(18'd123, 17'd456, 1'b1);
    collectResult("backpressure", 5);
    applyStimulus(18'd5, 17'd0, 1'b1);
    waitValid();
    checkOutput("cleared_const", 32'(out_data), 32'd5);
    collectResult("cleared", 0);

    // Asynchronous reset while the block is in its high-half resolve cycle.
    applyStimulus(18'd3, 17'd4, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    @(posedge clk); #1;
    applyStimulus(18'd7, 17'd1, 1'b1);
    waitValid();
    checkOutput("postrst_const", 32'(out_data), 32'd8);
    checkOutput("postrst_beats", 32'(out_beats), 32'd1);
    collectResult("postrst", 0);

    for (int k = 0; k < 30; k++) begin
      int nb;
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        applyStimulus(S_WIDTH'($urandom), C_WIDTH'($urandom), b == nb - 1);
      end
      collectResult("rand", $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
